i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h50, 7-bit target address to which the block responds.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 clk  input  1  system clock.
REQ-004 scl  input  1  I2C clock from bus; never driven by this block, so no clock stretching.
REQ-005 sda  inout  1  I2C data line; open-drain, either 0 or high-Z.
REQ-006 rx_data  output  8  last data byte received from the initiator.
REQ-007 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-008 rx_ack_en  input  1  1 = ACK received data bytes, 0 = NACK them; sampled at the 8th SCL rise of a write data byte.
REQ-009 tx_data  input  8  next byte to send to the initiator.
REQ-010 tx_req  output  1  one-cycle pulse requesting tx_data for the next read byte.
REQ-011 selected  output  1  1 from address ACK until the next START or STOP.
REQ-012 rw  output  1  R/W bit of the last matched address byte: 1 = read, 0 = write.
REQ-013 nack_rcvd  output  1  one-cycle pulse when the initiator NACKs a read byte.

Function
REQ-014 scl and sda each pass through a 2-flop synchronizer; all edge and condition detection uses the synchronized values and their 1-cycle-delayed copies.
REQ-015 START: synced sda falls while synced scl is high. STOP: synced sda rises while synced scl is high.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, WAIT.
REQ-017 START from any state -> ADDR, bit counter cleared, sda released, selected=0; this covers repeated START.
REQ-018 STOP from any state -> IDLE, sda released, selected=0.
REQ-019 START/STOP take priority over any bit event in the same cycle.
REQ-020 Input bits are sampled on the synced SCL rising edge; the shift register shifts MSB first.
REQ-021 sda output changes only in the cycle after a detected SCL falling edge; it never changes while SCL is high.
REQ-022 ADDR: after 8 bits, if bits[7:1]==ADDR, latch rw=bit0 and go to ADDR_ACK; otherwise go to WAIT with sda released.
REQ-023 ADDR_ACK: pull sda low from the SCL fall after bit 8 until the SCL fall after bit 9; set selected=1.
REQ-024 ADDR_ACK with rw=1: pulse tx_req at the 9th SCL rise; load tx_data into the shift register at the 9th SCL fall; then RDATA.
REQ-025 ADDR_ACK with rw=0: next state is WDATA.
REQ-026 WDATA: after 8 bits, at the 8th SCL rise, set rx_data, pulse rx_valid and latch rx_ack_en; then WACK.
REQ-027 WACK: drive sda = ~latched rx_ack_en for the 9th clock; then return to WDATA.
REQ-028 WACK after a NACK: go to WAIT instead of WDATA.
REQ-029 RDATA: drive sda = shift MSB after each SCL fall; after 8 bits release sda and go to RACK.
REQ-030 RACK, initiator ACK (sda low at 9th SCL rise): pulse tx_req; load tx_data at the 9th SCL fall; go to RDATA.
REQ-031 RACK, initiator NACK (sda high at 9th SCL rise): pulse nack_rcvd and go to WAIT.
REQ-032 WAIT: sda released; leaves only on START or STOP.
REQ-033 The bit counter is 3 bits plus an ACK phase; it clears on START and at the end of each ACK bit; no other wrap.
REQ-034 General call address 0x00 and 10-bit addressing are not supported; they are treated as a mismatch.
REQ-035 rx_valid, tx_req and nack_rcvd are mutually exclusive in any cycle.

Reset
REQ-036 On rst: state IDLE; sda released; rx_data=0; rx_valid=0; tx_req=0; nack_rcvd=0; selected=0; rw=0; synchronizers=1.
REQ-037 Assertion of rst mid-transfer aborts it immediately.
REQ-038 After reset release, the block ignores the bus until the next START.

Verification
REQ-039 Write with ADDR=0x50, rx_ack_en=1: START, byte 0xA0, byte 0xA5, STOP -> sda low on both 9th clocks; rx_data=0xA5; one rx_valid pulse; selected 1 then 0.
REQ-040 Mismatch: START, byte 0xA2, byte 0x11 -> sda never driven low; no pulses; selected stays 0.
REQ-041 Read with tx_data=0x3C then 0xC3: START, 0xA1, initiator ACKs byte 1 and NACKs byte 2 -> bus sees 0x3C then 0xC3; tx_req pulses twice; nack_rcvd pulses once; then WAIT.
REQ-042 rx_ack_en=0 on write byte 0x77 -> sda high at 9th clock; rx_valid pulses; the following byte is ignored.
REQ-043 Repeated START after a write address, then 0xA1 -> rw=1; tx_req pulses; sda never changes while SCL is high.
REQ-044 rst asserted mid-read byte -> sda released within 1 cycle; all outputs at reset values.

Source files
------------

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target (slave) with 7-bit address match, byte write/read handshakes
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   scl               I2C clock from the bus (input only, no clock stretching)
//   sda               I2C data, open-drain (driven 0 or released)
//   rx_data/rx_valid  last received write byte and its one-cycle update pulse
//   rx_ack_en         1 = ACK received data bytes, 0 = NACK them
//   tx_data/tx_req    byte to send on reads, and the one-cycle request for it
//   selected          high from address ACK until the next START or STOP
//   rw                R/W bit of the last matched address byte
//   nack_rcvd         one-cycle pulse when the initiator NACKs a read byte
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack_en,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       selected,
    output logic       rw,
    output logic       nack_rcvd
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_WAIT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_scl_s1, r_scl_s2, r_scl_d;
    logic        r_sda_s1, r_sda_s2, r_sda_d;
    logic [2:0]  r_bitcnt, w_bitcnt_nxt;
    logic        r_ack_rise, w_ack_rise_nxt;   // ACK phase: 9th SCL rise already seen
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_sda_oe, w_sda_oe_nxt;
    logic [7:0]  r_rx_data, w_rx_data_nxt;
    logic        r_rx_valid, w_rx_valid_nxt;
    logic        r_tx_req, w_tx_req_nxt;
    logic        r_nack, w_nack_nxt;
    logic        r_selected, w_selected_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_ack_en, w_ack_en_nxt;

    logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_match, w_last_bit;
    logic [7:0]  w_byte;

    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    // SCL must be high on both samples so an SCL edge coinciding with an SDA edge is not a condition
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    // General call (all-zero address) never matches
    assign w_match    = (w_byte[7:1] == ADDR) && (w_byte[7:1] != 7'd0);
    assign w_last_bit = w_scl_rise && (r_bitcnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
        end else begin
            r_scl_s1 <= scl;      r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= sda;      r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start)     w_state_nxt = S_ADDR;
        else if (w_stop) w_state_nxt = S_IDLE;
        else begin
            case (r_state)
                S_ADDR:     if (w_last_bit) w_state_nxt = w_match ? S_ADDR_ACK : S_WAIT;
                S_ADDR_ACK: if (w_scl_fall && r_ack_rise) w_state_nxt = r_rw ? S_RDATA : S_WDATA;
                S_WDATA:    if (w_last_bit) w_state_nxt = S_WACK;
                S_WACK:     if (w_scl_fall && r_ack_rise) w_state_nxt = r_ack_en ? S_WDATA : S_WAIT;
                S_RDATA:    if (w_last_bit) w_state_nxt = S_RACK;
                S_RACK: begin
                    if (w_scl_rise && !r_ack_rise && r_sda_s2) w_state_nxt = S_WAIT;
                    else if (w_scl_fall && r_ack_rise)         w_state_nxt = S_RDATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_bitcnt_nxt   = r_bitcnt;
        w_ack_rise_nxt = r_ack_rise;
        w_shift_nxt    = r_shift;
        w_sda_oe_nxt   = r_sda_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_nack_nxt     = 1'b0;
        w_selected_nxt = r_selected;
        w_rw_nxt       = r_rw;
        w_ack_en_nxt   = r_ack_en;
        if (w_start || w_stop) begin
            w_bitcnt_nxt   = 3'd0;
            w_ack_rise_nxt = 1'b0;
            w_sda_oe_nxt   = 1'b0;
            w_selected_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        // Counter holds at 7 through the ACK bit; the ACK end clears it
                        if (r_bitcnt != 3'd7) w_bitcnt_nxt = r_bitcnt + 3'd1;
                        else if (r_state == S_ADDR) begin
                            if (w_match) w_rw_nxt = w_byte[0];
                        end else begin
                            w_rx_data_nxt  = w_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_ack_en_nxt   = rx_ack_en;
                        end
                    end
                end
                S_ADDR_ACK, S_WACK: begin
                    if (w_scl_rise) begin
                        w_ack_rise_nxt = 1'b1;
                        if (r_state == S_ADDR_ACK && r_rw) w_tx_req_nxt = 1'b1;
                    end
                    if (w_scl_fall) begin
                        if (!r_ack_rise) begin
                            w_sda_oe_nxt = (r_state == S_ADDR_ACK) ? 1'b1 : r_ack_en;
                            if (r_state == S_ADDR_ACK) w_selected_nxt = 1'b1;
                        end else begin
                            w_ack_rise_nxt = 1'b0;
                            w_bitcnt_nxt   = 3'd0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                w_shift_nxt  = tx_data;
                                w_sda_oe_nxt = ~tx_data[7];
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise && r_bitcnt != 3'd7) w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (w_scl_fall) begin
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt = ~r_shift[6];
                    end
                end
                S_RACK: begin
                    if (w_scl_rise && !r_ack_rise) begin
                        w_ack_rise_nxt = 1'b1;
                        if (r_sda_s2) w_nack_nxt   = 1'b1;
                        else          w_tx_req_nxt = 1'b1;
                    end
                    if (w_scl_fall) begin
                        if (!r_ack_rise) begin
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_ack_rise_nxt = 1'b0;
                            w_bitcnt_nxt   = 3'd0;
                            w_shift_nxt    = tx_data;
                            w_sda_oe_nxt   = ~tx_data[7];
                        end
                    end
                end
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt   <= 3'd0;
            r_ack_rise <= 1'b0;
            r_shift    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_nack     <= 1'b0;
            r_selected <= 1'b0;
            r_rw       <= 1'b0;
            r_ack_en   <= 1'b0;
        end else begin
            r_bitcnt   <= w_bitcnt_nxt;
            r_ack_rise <= w_ack_rise_nxt;
            r_shift    <= w_shift_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_nack     <= w_nack_nxt;
            r_selected <= w_selected_nxt;
            r_rw       <= w_rw_nxt;
            r_ack_en   <= w_ack_en_nxt;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_req    = r_tx_req;
    assign nack_rcvd = r_nack;
    assign selected  = r_selected;
    assign rw        = r_rw;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed self-checking bench for i2c_target
module tb_i2c_target;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       rx_ack_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, selected, rw, nack_rcvd;
    wire        sda_bus;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_target #(.ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .scl(m_scl), .sda(sda_bus),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack_en(rx_ack_en),
        .tx_data(tx_data), .tx_req(tx_req), .selected(selected),
        .rw(rw), .nack_rcvd(nack_rcvd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: pulse counts, exclusivity, target drive, SDA changes under SCL high
    int n_rxv = 0, n_txr = 0, n_nack = 0, n_excl = 0, n_dut_low = 0, n_hi_chg = 0;
    logic p_scl = 1'b1, p_sda = 1'b1, p_mlow = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid)  n_rxv++;
            if (tx_req)    n_txr++;
            if (nack_rcvd) n_nack++;
            if ((32'(rx_valid) + 32'(tx_req) + 32'(nack_rcvd)) > 32'd1) n_excl++;
            if (sda_bus == 1'b0 && !m_sda_low) n_dut_low++;
            if (m_scl && p_scl && (sda_bus != p_sda) && (m_sda_low == p_mlow)) n_hi_chg++;
        end
        p_scl  = m_scl;
        p_sda  = sda_bus;
        p_mlow = m_sda_low;
    end

    task automatic wq;
        repeat (Q) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start;
        m_sda_low = 1'b0; wq;
        m_scl = 1'b1;     wq;
        m_sda_low = 1'b1; wq;
        m_scl = 1'b0;     wq;
    endtask

    task automatic i2c_stop;
        m_sda_low = 1'b1; wq;
        m_scl = 1'b1;     wq;
        m_sda_low = 1'b0; wq;
    endtask

    task automatic bit_xfer(input logic drive, output logic sampled);
        m_sda_low = ~drive; wq;
        m_scl = 1'b1;       wq;
        sampled = sda_bus;  wq;
        m_scl = 1'b0;       wq;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_bit);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack_bit);
    endtask

    task automatic read_byte(input logic ack, input logic [7:0] nxt, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        tx_data = nxt;
        bit_xfer(~ack, s);
    endtask

    logic       a;
    logic [7:0] d;
    int b_rxv, b_txr, b_nack, b_low;

    initial begin
        repeat (4) @(posedge clk);
        #2;
        check("rst_sda", 32'(sda_bus), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_pulses", 32'({rx_valid, tx_req, nack_rcvd}), 32'd0);
        check("rst_sel_rw", 32'({selected, rw}), 32'd0);
        rst = 1'b0;
        wq;

        // Write 0xA5 to address 0x50
        b_rxv = n_rxv;
        i2c_start;
        write_byte(8'hA0, a);
        check("wr_addr_ack", 32'(a), 32'd0);
        check("wr_selected", 32'(selected), 32'd1);
        check("wr_rw", 32'(rw), 32'd0);
        write_byte(8'hA5, a);
        check("wr_data_ack", 32'(a), 32'd0);
        check("wr_rx_data", 32'(rx_data), 32'hA5);
        check("wr_rx_valid_cnt", 32'(n_rxv - b_rxv), 32'd1);
        i2c_stop;
        check("wr_unselected", 32'(selected), 32'd0);

        // Address mismatch
        b_rxv = n_rxv; b_txr = n_txr; b_nack = n_nack; b_low = n_dut_low;
        i2c_start;
        write_byte(8'hA2, a);
        check("mm_addr_nack", 32'(a), 32'd1);
        write_byte(8'h11, a);
        check("mm_data_nack", 32'(a), 32'd1);
        check("mm_no_drive", 32'(n_dut_low - b_low), 32'd0);
        check("mm_no_pulses", 32'((n_rxv - b_rxv) + (n_txr - b_txr) + (n_nack - b_nack)), 32'd0);
        check("mm_selected", 32'(selected), 32'd0);
        i2c_stop;

        // Read two bytes, ACK then NACK
        b_txr = n_txr; b_nack = n_nack;
        tx_data = 8'h3C;
        i2c_start;
        write_byte(8'hA1, a);
        check("rd_addr_ack", 32'(a), 32'd0);
        check("rd_rw", 32'(rw), 32'd1);
        read_byte(1'b1, 8'hC3, d);
        check("rd_byte1", 32'(d), 32'h3C);
        read_byte(1'b0, 8'h99, d);
        check("rd_byte2", 32'(d), 32'hC3);
        check("rd_tx_req_cnt", 32'(n_txr - b_txr), 32'd2);
        check("rd_nack_cnt", 32'(n_nack - b_nack), 32'd1);
        read_byte(1'b0, 8'h99, d);
        check("rd_wait_released", 32'(d), 32'hFF);
        check("rd_wait_tx_req", 32'(n_txr - b_txr), 32'd2);
        i2c_stop;

        // Data NACK via rx_ack_en=0, following byte ignored
        rx_ack_en = 1'b0;
        b_rxv = n_rxv;
        i2c_start;
        write_byte(8'hA0, a);
        check("nk_addr_ack", 32'(a), 32'd0);
        write_byte(8'h77, a);
        check("nk_data_nack", 32'(a), 32'd1);
        check("nk_rx_data", 32'(rx_data), 32'h77);
        write_byte(8'h55, a);
        check("nk_ignored_ack", 32'(a), 32'd1);
        check("nk_rx_data_hold", 32'(rx_data), 32'h77);
        check("nk_rx_valid_cnt", 32'(n_rxv - b_rxv), 32'd1);
        i2c_stop;
        rx_ack_en = 1'b1;

        // Repeated START: write address, then read address
        b_txr = n_txr;
        tx_data = 8'h5A;
        i2c_start;
        write_byte(8'hA0, a);
        check("rs_w_ack", 32'(a), 32'd0);
        check("rs_rw0", 32'(rw), 32'd0);
        i2c_start;
        check("rs_sel_cleared", 32'(selected), 32'd0);
        write_byte(8'hA1, a);
        check("rs_r_ack", 32'(a), 32'd0);
        check("rs_rw1", 32'(rw), 32'd1);
        check("rs_tx_req_cnt", 32'(n_txr - b_txr), 32'd1);
        read_byte(1'b0, 8'h00, d);
        check("rs_byte", 32'(d), 32'h5A);
        i2c_stop;

        // Reset in the middle of a read byte
        tx_data = 8'h00;
        i2c_start;
        write_byte(8'hA1, a);
        m_sda_low = 1'b0; wq;
        m_scl = 1'b1; wq; wq;
        m_scl = 1'b0; wq;
        check("mr_driving", 32'(sda_bus), 32'd0);
        rst = 1'b1;
        #1;
        check("mr_sda_released", 32'(sda_bus), 32'd1);
        @(negedge clk);
        check("mr_rx_data", 32'(rx_data), 32'h00);
        check("mr_flags", 32'({rx_valid, tx_req, nack_rcvd, selected, rw}), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wq;
        // Without a START the target stays silent
        write_byte(8'hA0, a);
        check("mr_ignore_bus", 32'(a), 32'd1);
        i2c_stop;

        check("pulse_exclusive", 32'(n_excl), 32'd0);
        check("no_change_scl_high", 32'(n_hi_chg), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
